// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the windowed sum accumulator.
package sum_acc_pkg;

  localparam int IN_W = 5;
  localparam int WIN  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sum_acc_state_t;

endpackage

// File: rtl/sum_minmax_tracker.sv
// Running max/min register pair. clr opens a fresh window (max=0, min=all-ones).
module sum_minmax_tracker #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] max,
  output logic [W-1:0] min
);

  // Strict compares: an equal sample leaves the stored extreme untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      max <= '0;
      min <= '0;
    end else if (clr) begin
      max <= '0;
      min <= '1;
    end else if (en) begin
      if (d > max) max <= d;
      if (d < min) min <= d;
    end
  end

endmodule

// File: rtl/sum_window_acc.sv
// Collects WIN valid adder sums and reports total/max/min through a
// valid/ready result port. FSM: IDLE -> ACCUM -> DONE -> IDLE.
module sum_window_acc
  import sum_acc_pkg::sum_acc_state_t;
#(
  parameter int IN_W  = sum_acc_pkg::IN_W,
  parameter int WIN   = sum_acc_pkg::WIN,
  parameter int ACC_W = IN_W + $clog2(WIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [IN_W-1:0]  out_max,
  output logic [IN_W-1:0]  out_min,
  output logic             busy,
  output sum_acc_state_t   dbg_state
);

  localparam int CNT_W = $clog2(WIN + 1);

  sum_acc_state_t   state;
  sum_acc_state_t   state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] total;
  logic             clr;
  logic             accept;
  logic             last;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready depends only on state; out_valid, once raised, holds
  // with stable data until out_ready is seen.
  assign clr    = (state == sum_acc_pkg::IDLE) && start;
  assign accept = in_valid && in_ready;
  assign last   = (cnt == CNT_W'(WIN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= sum_acc_pkg::IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      sum_acc_pkg::IDLE:  if (start)              state_nxt = sum_acc_pkg::ACCUM;
      sum_acc_pkg::ACCUM: if (accept && last)     state_nxt = sum_acc_pkg::DONE;
      sum_acc_pkg::DONE:  if (out_ready)          state_nxt = sum_acc_pkg::IDLE;
      default:                                    state_nxt = sum_acc_pkg::IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == sum_acc_pkg::ACCUM);
    out_valid = (state == sum_acc_pkg::DONE);
    busy      = (state != sum_acc_pkg::IDLE);
  end

  // Results survive the handshake and are only wiped by the next start.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      total <= '0;
    end else if (accept) begin
      cnt   <= cnt + 1'b1;
      total <= total + ACC_W'(in_sum);
    end
  end

  sum_minmax_tracker #(.W(IN_W)) u_minmax (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (accept),
    .d   (in_sum),
    .max (out_max),
    .min (out_min)
  );

  assign out_total = total;
  assign dbg_state = state;

endmodule

// File: tb/tb_sum_window_acc.sv
// Bench for sum_window_acc: directed windows with literal results, then
// random windows checked cycle-by-cycle against a queue-based model.
module tb_sum_window_acc;

  localparam int IN_W  = 5;
  localparam int WIN   = 8;
  localparam int ACC_W = IN_W + $clog2(WIN);
  localparam int RES_W = ACC_W + 2 * IN_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_sum = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_total;
  logic [IN_W-1:0]  out_max;
  logic [IN_W-1:0]  out_min;
  logic             busy;
  sum_acc_pkg::sum_acc_state_t dbg_state;

  sum_window_acc #(.IN_W(IN_W), .WIN(WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_max   (out_max),
    .out_min   (out_min),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   cyc       = 0;
  logic armed     = 1'b0;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- model ----------------
  // mode: 0 waiting for start, 1 collecting samples, 2 result offered.
  int               mode = 0;
  logic [IN_W-1:0]  win_q[$];
  logic [ACC_W-1:0] m_total = '0;
  logic [IN_W-1:0]  m_max = '0;
  logic [IN_W-1:0]  m_min = '0;
  logic [RES_W-1:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      mode = 0; win_q.delete(); exp_q.delete();
      m_total = '0; m_max = '0; m_min = '0;
    end else if (mode == 0) begin
      if (start) begin
        mode = 1; win_q.delete();
        m_total = '0; m_max = '0; m_min = '1;
      end
    end else if (mode == 1) begin
      if (in_valid) begin
        win_q.push_back(in_sum);
        m_total = '0; m_max = '0; m_min = '1;
        foreach (win_q[i]) begin
          m_total = m_total + ACC_W'(win_q[i]);
          if (win_q[i] > m_max) m_max = win_q[i];
          if (win_q[i] < m_min) m_min = win_q[i];
        end
        if (win_q.size() == WIN) begin
          mode = 2;
          exp_q.push_back({m_total, m_max, m_min});
        end
      end
    end else begin
      if (out_ready) mode = 0;
    end
  end

  // ---------------- compare ----------------
  initial forever begin
    logic [RES_W-1:0] e;
    @(negedge clk);
    if (armed) begin
      check("in_ready",  32'(in_ready),  32'(mode == 1));
      check("out_valid", 32'(out_valid), 32'(mode == 2));
      check("busy",      32'(busy),      32'(mode != 0));
      check("out_total", 32'(out_total), 32'(m_total));
      check("out_max",   32'(out_max),   32'(m_max));
      check("out_min",   32'(out_min),   32'(m_min));
      if (mode == 2 && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_total", 32'(out_total), 32'(e[RES_W-1 -: ACC_W]));
          check("sb_max",   32'(out_max),   32'(e[2*IN_W-1 -: IN_W]));
          check("sb_min",   32'(out_min),   32'(e[IN_W-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic start_window(output int c0);
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [IN_W-1:0] v);
    in_valid = 1'b1;
    in_sum   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input int t, input int mx, input int mn);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_total"}, 32'(out_total), 32'(t));
    check({name, "_max"},   32'(out_max),   32'(mx));
    check({name, "_min"},   32'(out_min),   32'(mn));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, acc, n;
    bit done;
    logic [IN_W-1:0] bp_vals[8];

    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;
    check("rst_total", 32'(out_total), 32'd0);
    check("rst_max",   32'(out_max),   32'd0);
    check("rst_min",   32'(out_min),   32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(sum_acc_pkg::IDLE));

    // Basic: 1..8 back-to-back
    start_window(c0);
    for (int v = 1; v <= 8; v++) send(IN_W'(v));
    check_result("basic", 36, 8, 1);
    check("basic_latency", 32'(cyc - c0), 32'd9);
    handshake();
    check("basic_after_valid", 32'(out_valid), 32'd0);
    check("basic_kept_total",  32'(out_total), 32'd36);

    // Extremes
    start_window(c0);
    repeat (8) send(5'd31);
    check_result("all31", 248, 31, 31);
    handshake();
    start_window(c0);
    repeat (8) send(5'd0);
    check_result("all0", 0, 0, 0);
    handshake();

    // Gaps and drops: offers in IDLE are ignored
    repeat (3) send(5'd31);
    start_window(c0);
    for (int i = 1; i <= 8; i++) begin
      send(IN_W'(2 * i));
      if (i < 8) begin
        in_sum = 5'd31;
        @(posedge clk); #1;
      end
    end
    check_result("gaps", 72, 16, 2);
    handshake();

    // Back-pressure with ignored start pulses
    bp_vals = '{5'd7, 5'd3, 5'd12, 5'd9, 5'd20, 5'd1, 5'd15, 5'd6};
    start_window(c0);
    foreach (bp_vals[i]) send(bp_vals[i]);
    for (int k = 0; k < 5; k++) begin
      start = k[0];
      @(posedge clk); #1;
      check_result("bp_hold", 73, 20, 1);
    end
    start = 1'b1;
    handshake();
    start = 1'b0;
    check("bp_done_valid", 32'(out_valid), 32'd0);
    check("bp_done_busy",  32'(busy),      32'd0);
    check("bp_done_state", 32'(dbg_state), 32'(sum_acc_pkg::IDLE));
    check("bp_kept_total", 32'(out_total), 32'd73);

    // Reset mid-window
    start_window(c0);
    repeat (4) send(5'd25);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_total", 32'(out_total), 32'd0);
    check("mid_rst_max",   32'(out_max),   32'd0);
    check("mid_rst_min",   32'(out_min),   32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd0);
    start_window(c0);
    repeat (8) send(5'd3);
    check_result("post_rst", 24, 3, 3);
    handshake();

    // Random windows
    for (int w = 0; w < 200; w++) begin
      start_window(c0);
      acc = 0; n = 0;
      while (acc < WIN && n < 200) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sum   = IN_W'($urandom_range(0, 31));
        start    = ($urandom_range(0, 7) == 0);
        if (in_valid && in_ready) acc++;
        @(posedge clk); #1;
        n++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      done = 1'b0; n = 0;
      while (!done && n < 200) begin
        out_ready = ($urandom_range(0, 1) == 1);
        if (out_valid && out_ready) done = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      out_ready = 1'b0;
      check("rand_window_done", 32'(done), 32'd1);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
